// File: rtl/serial_add_sequencer_if.sv
// Bundle of every non-clock/reset signal of the serial add sequencer.
// The slave modport is the sequencer's view; master is the surrounding
// environment (operand source, adder and result sink).
interface serial_add_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   // Operand input port.
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         in_a;
   logic [WIDTH-1:0]         in_b;
   // Serial adder side.
   logic                     add_start;
   logic [WIDTH-1:0]         add_data_a;
   logic [WIDTH-1:0]         add_data_b;
   logic [WIDTH-1:0]         add_out;
   logic                     add_done;
   // Result port and status.
   logic                     res_valid;
   logic                     res_ready;
   logic [WIDTH-1:0]         res_sum;
   logic                     res_err;
   logic                     busy;
   logic [$clog2(DEPTH):0]   fifo_count;

   modport slave (
      input  in_valid, in_a, in_b, add_out, add_done, res_ready,
      output in_ready, add_start, add_data_a, add_data_b,
             res_valid, res_sum, res_err, busy, fifo_count
   );

   modport master (
      output in_valid, in_a, in_b, add_out, add_done, res_ready,
      input  in_ready, add_start, add_data_a, add_data_b,
             res_valid, res_sum, res_err, busy, fifo_count
   );
endinterface

// File: rtl/serial_add_sequencer.sv
// Front-end for a serial adder: queues operand pairs in a small FIFO,
// launches one add at a time with a single-cycle start pulse, waits for
// done (or a timeout) and presents the sum on a valid/ready result port.
module serial_add_sequencer #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_add_sequencer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, START, WAIT, RESULT} state_t;

   state_t           state;
   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [TW-1:0]    wait_cnt;
   logic             push;
   logic             pop;

   logic             add_start_q;
   logic [WIDTH-1:0] data_a_q;
   logic [WIDTH-1:0] data_b_q;
   logic             res_valid_q;
   logic [WIDTH-1:0] res_sum_q;
   logic             res_err_q;
   logic             busy_q;

   // Readiness depends on occupancy alone, so a full FIFO never accepts,
   // even when the head is leaving in the same cycle.
   assign bus.in_ready = (count < CW'(DEPTH));
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = (state == IDLE) && (count != '0) && !res_valid_q;

   assign bus.add_start  = add_start_q;
   assign bus.add_data_a = data_a_q;
   assign bus.add_data_b = data_b_q;
   assign bus.res_valid  = res_valid_q;
   assign bus.res_sum    = res_sum_q;
   assign bus.res_err    = res_err_q;
   assign bus.busy       = busy_q;
   assign bus.fifo_count = count;

   // Operand storage, written at the tail on every accepted push.
   // NOTE: storage is not reset; the pointers and count define which
   // entries are meaningful, so resetting the array would only add logic.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr] <= bus.in_a;
         mem_b[wr_ptr] <= bus.in_b;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Launch / wait / result sequencing; every output it drives is registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         add_start_q <= 1'b0;
         data_a_q    <= '0;
         data_b_q    <= '0;
         res_valid_q <= 1'b0;
         res_sum_q   <= '0;
         res_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         // NOTE: the start pulse defaults low every cycle, so it is high only
         // in the single cycle following the launch edge.
         add_start_q <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  data_a_q    <= mem_a[rd_ptr];
                  data_b_q    <= mem_b[rd_ptr];
                  add_start_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state       <= START;
               end
            end
            START: begin
               // done may still reflect the previous add here, so it is ignored.
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + TW'(1);
               if (bus.add_done) begin
                  res_sum_q   <= bus.add_out;
                  res_err_q   <= 1'b0;
                  res_valid_q <= 1'b1;
                  state       <= RESULT;
               end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                  res_sum_q   <= '0;
                  res_err_q   <= 1'b1;
                  res_valid_q <= 1'b1;
                  state       <= RESULT;
               end
            end
            RESULT: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer: a behavioural serial-adder responder,
// a queue-based reference model checked every cycle, and directed tests
// with hand-computed sums and latencies.
module tb_serial_add_sequencer;
   localparam int WIDTH   = 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_add_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   serial_add_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
   endtask

   // Serial adder stand-in: done rises WIDTH edges after start is sampled
   // and stays high until the next start; 'hang' suppresses done entirely.
   logic hang = 1'b0;
   int   add_cnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_cnt      <= 0;
         bus.add_done <= 1'b0;
         bus.add_out  <= '0;
      end else if (bus.add_start) begin
         add_cnt      <= WIDTH;
         bus.add_done <= 1'b0;
         bus.add_out  <= '0;
      end else if (add_cnt != 0) begin
         add_cnt <= add_cnt - 1;
         if (add_cnt == 1 && !hang) begin
            bus.add_done <= 1'b1;
            bus.add_out  <= bus.add_data_a + bus.add_data_b;
         end
      end
   end

   // Reference model: operands flow through a launch queue and a result
   // queue in push order; occupancy is pushes minus launches.
   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             err;
   } op_t;

   op_t              launch_q[$];
   op_t              result_q[$];
   int               mcount    = 0;
   bit               push_prev = 1'b0;
   bit               start_prev = 1'b0;
   bit               hold_prev = 1'b0;
   bit               hs_prev   = 1'b0;
   bit               in_flight = 1'b0;
   bit               seen_full = 1'b0;
   logic [WIDTH-1:0] cur_a     = '0;
   logic [WIDTH-1:0] cur_b     = '0;

   always @(negedge clk) begin
      op_t              op;
      logic [WIDTH-1:0] exp_sum;
      if (!rst_n) begin
         launch_q.delete();
         result_q.delete();
         mcount    = 0;
         push_prev = 1'b0;
         start_prev = 1'b0;
         hold_prev = 1'b0;
         hs_prev   = 1'b0;
         in_flight = 1'b0;
         cur_a     = '0;
         cur_b     = '0;
         check("reset_outputs", {bus.add_start, bus.add_data_a, bus.add_data_b, bus.res_valid,
                                 bus.res_sum, bus.res_err, bus.busy, bus.fifo_count}, 32'd0);
         check("reset_in_ready", bus.in_ready, 32'd1);
      end else begin
         mcount = mcount + int'(push_prev) - int'(bus.add_start);
         check("fifo_count", bus.fifo_count, mcount);
         check("in_ready", bus.in_ready, mcount < DEPTH);
         if (mcount == DEPTH) seen_full = 1'b1;

         if (hs_prev) in_flight = 1'b0;
         if (bus.add_start) in_flight = 1'b1;
         check("busy", bus.busy, in_flight);
         check("no_start_with_result", bus.add_start & bus.res_valid, 32'd0);

         if (bus.add_start) begin
            check("start_single_cycle", start_prev, 32'd0);
            if (launch_q.size() == 0) begin
               fail_now("launch_unexpected");
            end else begin
               op = launch_q.pop_front();
               cur_a = op.a;
               cur_b = op.b;
               check("launch_a", bus.add_data_a, cur_a);
               check("launch_b", bus.add_data_b, cur_b);
            end
         end else if (bus.busy) begin
            check("hold_a", bus.add_data_a, cur_a);
            check("hold_b", bus.add_data_b, cur_b);
         end

         if (hold_prev) check("res_valid_hold", bus.res_valid, 32'd1);
         if (bus.res_valid) begin
            if (result_q.size() == 0) begin
               fail_now("result_unexpected");
            end else begin
               op = result_q[0];
               exp_sum = op.err ? '0 : op.a + op.b;
               check("res_sum", bus.res_sum, exp_sum);
               check("res_err", bus.res_err, op.err);
               if (bus.res_ready) void'(result_q.pop_front());
            end
         end

         hold_prev  = bus.res_valid && !bus.res_ready;
         hs_prev    = bus.res_valid && bus.res_ready;
         start_prev = bus.add_start;
         push_prev  = bus.in_valid && (mcount < DEPTH);
         if (push_prev) begin
            op = '{a: bus.in_a, b: bus.in_b, err: hang};
            launch_q.push_back(op);
            result_q.push_back(op);
         end
      end
   end

   // Offer one pair until accepted; 'at' is the cycle of acceptance.
   task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int at);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      at           = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            at = cyc;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      fail_now("push_accept");
   endtask

   task automatic wait_start(output int at);
      at = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.add_start) begin
            at = cyc;
            return;
         end
      end
      fail_now("wait_start");
   endtask

   task automatic wait_res(output int at, output logic [WIDTH-1:0] sum, output logic err);
      at  = -1;
      sum = '0;
      err = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.res_valid) begin
            at  = cyc;
            sum = bus.res_sum;
            err = bus.res_err;
            return;
         end
      end
      fail_now("wait_res");
   endtask

   task automatic drain();
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (result_q.size() == 0 && launch_q.size() == 0 && mcount == 0 && !bus.busy) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      fail_now("drain");
   endtask

   logic [WIDTH-1:0] pairs_a [6] = '{8'h01, 8'h10, 8'h7F, 8'h80, 8'hC3, 8'hFE};
   logic [WIDTH-1:0] pairs_b [6] = '{8'h02, 8'h20, 8'h01, 8'h80, 8'h3C, 8'h03};

   initial begin
      int               n, s, r;
      logic [WIDTH-1:0] sum;
      logic             err;

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.res_ready = 1'b1;
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: single add, latency and sum pinned by hand.
      push(8'h25, 8'h5A, n);
      wait_start(s);
      check("t1_start_latency", s - n, 32'd2);
      wait_res(r, sum, err);
      check("t1_result_latency", r - n, 32'd12);
      check("t1_sum", sum, 32'h7F);
      check("t1_err", err, 32'd0);
      drain();

      // 2: carry-out is dropped.
      push(8'hFF, 8'h01, n);
      wait_res(r, sum, err);
      check("t2_sum", sum, 32'h00);
      check("t2_err", err, 32'd0);
      drain();

      // 3: six pairs back-to-back; FIFO must fill, results in order.
      seen_full = 1'b0;
      for (int i = 0; i < 6; i++) push(pairs_a[i], pairs_b[i], n);
      drain();
      check("t3_fifo_filled", seen_full, 32'd1);

      // 4: result stalled for 30 cycles while the FIFO fills behind it.
      bus.res_ready = 1'b0;
      push(8'h10, 8'h20, n);
      wait_res(r, sum, err);
      @(posedge clk);
      #1;
      push(8'h01, 8'h01, n);
      push(8'h02, 8'h02, n);
      push(8'h03, 8'h03, n);
      push(8'h04, 8'h04, n);
      while (cyc < r + 30) @(negedge clk);
      check("t4_valid_held", bus.res_valid, 32'd1);
      check("t4_sum_held", bus.res_sum, 32'h30);
      check("t4_fifo_full", bus.fifo_count, 32'd4);
      check("t4_in_ready_low", bus.in_ready, 32'd0);
      @(posedge clk);
      #1 bus.res_ready = 1'b1;
      drain();

      // 5: hung adder times out after TIMEOUT wait cycles, then recovery.
      hang = 1'b1;
      push(8'h33, 8'h44, n);
      wait_start(s);
      wait_res(r, sum, err);
      check("t5_timeout_latency", r - s, TIMEOUT + 1);
      check("t5_sum_zero", sum, 32'h00);
      check("t5_err", err, 32'd1);
      @(posedge clk);
      #1 hang = 1'b0;
      push(8'h01, 8'h02, n);
      wait_res(r, sum, err);
      check("t5_recover_sum", sum, 32'h03);
      check("t5_recover_err", err, 32'd0);
      drain();

      // 6: reset while waiting with two pairs queued.
      push(8'h11, 8'h22, n);
      push(8'h12, 8'h23, n);
      push(8'h13, 8'h24, n);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t6_queued", bus.fifo_count, 32'd2);
      check("t6_busy_before", bus.busy, 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("t6_fifo_cleared", bus.fifo_count, 32'd0);
      check("t6_busy_cleared", bus.busy, 32'd0);
      check("t6_start_low", bus.add_start, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      push(8'h40, 8'h02, n);
      wait_res(r, sum, err);
      check("t6_after_reset_sum", sum, 32'h42);
      check("t6_after_reset_err", err, 32'd0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end
endmodule
